// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared definitions for the fetch PC generator: 2-bit
//                direction counter encodings, saturating counter helpers
//                and the default reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  typedef logic [1:0] ctr_t;

  // Direction counter states: strongly/weakly not-taken, weakly/strongly taken
  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen_bp_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_bp_if
//  Description : Bundle between the ID/EX stage and the fetch PC generator.
//                Carries stall/redirect control, jr register target,
//                branch-resolution updates and the fetch PC / prediction.
//  Ports       : master - pipeline side (drives control, sees PC)
//                slave  - pc_gen_bp side (sees control, drives PC)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_gen_bp_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            redirect_i;
  logic            redirect_jr_i;
  logic [XLEN-1:0] jr_reg_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;
  logic [XLEN-1:0] pc_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;

  modport master (
    output stall_i, redirect_i, redirect_jr_i, jr_reg_i, redirect_pc_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    input  pc_o, pred_taken_o, pred_target_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_jr_i, jr_reg_i, redirect_pc_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    output pc_o, pred_taken_o, pred_target_o
  );
endinterface
`default_nettype wire

// File: rtl/pc_btb.sv
`default_nettype none
// ============================================================================
//  Module      : pc_btb
//  Description : Direct-mapped branch target buffer with 2-bit direction
//                counters. Combinational read port for the fetch PC and a
//                synchronous update port for resolved branches.
//  Ports       : clk, reset_n        - clock, async active-low reset
//                i_rd_pc             - lookup PC
//                o_rd_hit/taken/tgt  - lookup result
//                i_upd_*             - resolved branch update
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_btb
  import pc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  input  wire logic [XLEN-1:0] i_rd_pc,
  output logic                 o_rd_hit,
  output logic                 o_rd_taken,
  output logic [XLEN-1:0]      o_rd_target,
  input  wire logic            i_upd_valid,
  input  wire logic [XLEN-1:0] i_upd_pc,
  input  wire logic            i_upd_taken,
  input  wire logic [XLEN-1:0] i_upd_target
);

  localparam int c_IDX_W = $clog2(BTB_ENTRIES);
  localparam int c_TAG_W = XLEN - c_IDX_W - 2;

  logic              r_valid  [BTB_ENTRIES];
  logic [c_TAG_W-1:0] r_tag   [BTB_ENTRIES];
  logic [XLEN-1:0]   r_target [BTB_ENTRIES];
  ctr_t              r_ctr    [BTB_ENTRIES];

  logic [c_IDX_W-1:0] w_rd_idx;
  logic [c_TAG_W-1:0] w_rd_tag;
  logic [c_IDX_W-1:0] w_upd_idx;
  logic [c_TAG_W-1:0] w_upd_tag;
  logic               w_upd_hit;
  logic               w_unused;

  // Instructions are word aligned, so the low two PC bits never index.
  assign w_rd_idx  = i_rd_pc[c_IDX_W+1:2];
  assign w_rd_tag  = i_rd_pc[XLEN-1:c_IDX_W+2];
  assign w_upd_idx = i_upd_pc[c_IDX_W+1:2];
  assign w_upd_tag = i_upd_pc[XLEN-1:c_IDX_W+2];
  assign w_unused  = ^{i_rd_pc[1:0], i_upd_pc[1:0]};

  assign o_rd_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_taken  = o_rd_hit && r_ctr[w_rd_idx][1];
  assign o_rd_target = r_target[w_rd_idx];

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Reads see pre-update state; a write becomes visible on the next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_SNT;
      end
    end else if (i_upd_valid) begin
      if (w_upd_hit) begin
        if (i_upd_taken) begin
          r_ctr[w_upd_idx]    <= sat_inc(r_ctr[w_upd_idx]);
          r_target[w_upd_idx] <= i_upd_target;
        end else begin
          r_ctr[w_upd_idx]    <= sat_dec(r_ctr[w_upd_idx]);
        end
      end else if (i_upd_taken) begin
        // Allocate on a taken miss, evicting whatever aliased here before.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= i_upd_target;
        r_ctr[w_upd_idx]    <= CTR_WT;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_gen_bp.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_bp
//  Description : Fetch PC generator with BTB-based next-PC prediction.
//                Priority: reset > redirect > stall > prediction.
//  Ports       : clk      - clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - pc_gen_bp_if slave: stall, redirect (incl. jr),
//                           branch update in; pc_o and prediction out
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen_bp
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              BTB_ENTRIES  = 16,
  parameter logic [XLEN-1:0] RESET_PC     = DEFAULT_RESET_PC[XLEN-1:0],
  parameter int              JR_WORD_ADDR = 1
) (
  input wire logic  clk,
  input wire logic  reset_n,
  pc_gen_bp_if.slave bus
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_jr_target;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_btb_target;
  logic            w_btb_hit;
  logic            w_btb_taken;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;

  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_rd_pc      (r_pc),
    .o_rd_hit     (w_btb_hit),
    .o_rd_taken   (w_btb_taken),
    .o_rd_target  (w_btb_target),
    .i_upd_valid  (bus.upd_valid_i),
    .i_upd_pc     (bus.upd_pc_i),
    .i_upd_taken  (bus.upd_taken_i),
    .i_upd_target (bus.upd_target_i)
  );

  // Sequential fetch wraps modulo 2^XLEN.
  assign w_pc_plus4 = r_pc + XLEN'(4);

  generate
    if (JR_WORD_ADDR != 0) begin : g_jr_word
      // Register holds a word address; shifted-out top bits are dropped.
      assign w_jr_target = {bus.jr_reg_i[XLEN-3:0], 2'b00};
    end else begin : g_jr_byte
      assign w_jr_target = bus.jr_reg_i;
    end
  endgenerate

  // w_btb_taken already implies a hit; the hit itself is not needed further.
  assign w_pred_taken  = w_btb_taken && w_btb_hit;
  assign w_pred_target = w_pred_taken ? w_btb_target : w_pc_plus4;

  always_comb begin
    w_next_pc = w_pred_target;
    if (bus.redirect_i) begin
      w_next_pc = bus.redirect_jr_i ? w_jr_target : bus.redirect_pc_i;
    end else if (bus.stall_i) begin
      w_next_pc = r_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign bus.pc_o          = r_pc;
  assign bus.pred_taken_o  = w_pred_taken;
  assign bus.pred_target_o = w_pred_target;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_bp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen_bp
//  Description : Directed self-checking bench for pc_gen_bp. A second
//                instance with byte-addressed jr covers the other jr mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen_bp;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fails;

  pc_gen_bp_if #(.XLEN(32)) bus ();
  pc_gen_bp_if #(.XLEN(32)) bus0 ();

  pc_gen_bp #(
    .XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0), .JR_WORD_ADDR(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  pc_gen_bp #(
    .XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0), .JR_WORD_ADDR(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc,
                         input logic t, input logic [31:0] tgt);
    bus.upd_valid_i  = v;
    bus.upd_pc_i     = pc;
    bus.upd_taken_i  = t;
    bus.upd_target_i = tgt;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = pc;
    tick();
    bus.redirect_i    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n  = 1'b0;
    bus.stall_i = 0; bus.redirect_i = 0; bus.redirect_jr_i = 0;
    bus.jr_reg_i = 0; bus.redirect_pc_i = 0;
    set_upd(0, 0, 0, 0);
    bus0.stall_i = 0; bus0.redirect_i = 0; bus0.redirect_jr_i = 0;
    bus0.jr_reg_i = 0; bus0.redirect_pc_i = 0;
    bus0.upd_valid_i = 0; bus0.upd_pc_i = 0; bus0.upd_taken_i = 0;
    bus0.upd_target_i = 0;

    // Reset state
    repeat (2) tick();
    check_eq("rst_pc", bus.pc_o, 32'h0);
    check_eq("rst_taken", {31'b0, bus.pred_taken_o}, 32'h0);
    check_eq("rst_target", bus.pred_target_o, 32'h4);
    reset_n = 1'b1;

    // Free run
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("run_pc", bus.pc_o, 32'(k * 4));
      check_eq("run_taken", {31'b0, bus.pred_taken_o}, 32'h0);
    end

    // Train 0x10 taken -> 0x40
    set_upd(1, 32'h10, 1, 32'h40);
    tick();
    set_upd(0, 0, 0, 0);
    check_eq("train_pc", bus.pc_o, 32'h10);
    check_eq("train_taken", {31'b0, bus.pred_taken_o}, 32'h1);
    check_eq("train_target", bus.pred_target_o, 32'h40);
    tick();
    check_eq("taken_jump", bus.pc_o, 32'h40);

    // Two not-taken updates: ctr 2->1->0
    set_upd(1, 32'h10, 0, 32'h0);
    tick();
    tick();
    set_upd(0, 0, 0, 0);
    check_eq("nt_run_pc", bus.pc_o, 32'h48);
    redirect_to(32'h10);
    check_eq("nt_redir_pc", bus.pc_o, 32'h10);
    check_eq("nt_taken", {31'b0, bus.pred_taken_o}, 32'h0);
    check_eq("nt_target", bus.pred_target_o, 32'h14);
    tick();
    check_eq("nt_fall", bus.pc_o, 32'h14);

    // Stall with updates: taken x4 (0->1->2->3->3), not-taken x1 (->2)
    bus.stall_i = 1'b1;
    set_upd(1, 32'h10, 1, 32'h40);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("stall_hold", bus.pc_o, 32'h14);
    end
    set_upd(1, 32'h10, 0, 32'h0);
    tick();
    set_upd(0, 0, 0, 0);
    check_eq("stall_hold2", bus.pc_o, 32'h14);
    redirect_to(32'h10);   // redirect wins over the held stall
    check_eq("redir_over_stall", bus.pc_o, 32'h10);
    check_eq("sat_hi_taken", {31'b0, bus.pred_taken_o}, 32'h1);
    check_eq("sat_hi_target", bus.pred_target_o, 32'h40);

    // Still stalled: not-taken x3 (2->1->0->0), taken x1 (->1)
    set_upd(1, 32'h10, 0, 32'h0);
    repeat (3) tick();
    set_upd(1, 32'h10, 1, 32'h40);
    tick();
    set_upd(0, 0, 0, 0);
    check_eq("sat_lo_pc", bus.pc_o, 32'h10);
    check_eq("sat_lo_taken", {31'b0, bus.pred_taken_o}, 32'h0);
    check_eq("sat_lo_target", bus.pred_target_o, 32'h14);

    // jr redirect during stall, both addressing modes
    bus.redirect_i = 1; bus.redirect_jr_i = 1; bus.jr_reg_i = 32'h20;
    bus0.stall_i = 1; bus0.redirect_i = 1; bus0.redirect_jr_i = 1;
    bus0.jr_reg_i = 32'h20;
    tick();
    bus.redirect_i = 0; bus.redirect_jr_i = 0; bus.stall_i = 0;
    bus0.redirect_i = 0; bus0.redirect_jr_i = 0; bus0.stall_i = 0;
    check_eq("jr_word", bus.pc_o, 32'h80);
    check_eq("jr_byte", bus0.pc_o, 32'h20);

    // Aliasing: 0x50 evicts 0x10 at index 4
    set_upd(1, 32'h50, 1, 32'h100);
    tick();
    set_upd(0, 0, 0, 0);
    check_eq("alias_run", bus.pc_o, 32'h84);
    redirect_to(32'h10);
    check_eq("alias_miss_taken", {31'b0, bus.pred_taken_o}, 32'h0);
    check_eq("alias_miss_target", bus.pred_target_o, 32'h14);
    redirect_to(32'h50);
    check_eq("alias_hit_taken", {31'b0, bus.pred_taken_o}, 32'h1);
    check_eq("alias_hit_target", bus.pred_target_o, 32'h100);
    tick();
    check_eq("alias_jump", bus.pc_o, 32'h100);

    // No same-cycle bypass
    set_upd(1, 32'h100, 1, 32'h300);
    #1;
    check_eq("nobyp_taken", {31'b0, bus.pred_taken_o}, 32'h0);
    check_eq("nobyp_target", bus.pred_target_o, 32'h104);
    tick();
    set_upd(0, 0, 0, 0);
    check_eq("nobyp_pc", bus.pc_o, 32'h104);
    redirect_to(32'h100);
    check_eq("upd_visible", bus.pred_target_o, 32'h300);

    // Wrap at top of address space
    redirect_to(32'hFFFF_FFFC);
    check_eq("wrap_pc", bus.pc_o, 32'hFFFF_FFFC);
    check_eq("wrap_target", bus.pred_target_o, 32'h0);
    tick();
    check_eq("wrap_next", bus.pc_o, 32'h0);

    // Asynchronous reset mid-cycle with an update in flight
    repeat (2) tick();
    check_eq("pre_rst_pc", bus.pc_o, 32'h8);
    #2;
    reset_n = 1'b0;
    set_upd(1, 32'h10, 1, 32'h200);
    #1;
    check_eq("async_rst_pc", bus.pc_o, 32'h0);
    check_eq("async_rst_target", bus.pred_target_o, 32'h4);
    tick();
    set_upd(0, 0, 0, 0);
    reset_n = 1'b1;
    check_eq("rst_hold_pc", bus.pc_o, 32'h0);
    redirect_to(32'h10);
    check_eq("rst_clr_10", {31'b0, bus.pred_taken_o}, 32'h0);
    redirect_to(32'h50);
    check_eq("rst_clr_50", {31'b0, bus.pred_taken_o}, 32'h0);
    redirect_to(32'h100);
    check_eq("rst_clr_100", bus.pred_target_o, 32'h104);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_gen_bp.md
# pc_gen_bp

Parametrised fetch PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It sits at the front of the pipeline and drives the IF-stage PC. The ID/EX stage feeds it mispredict redirects, including `jr` register targets, and branch-resolution updates. It replaces fixed PC+4 / external-prediction sequencing with internal prediction and redirect-over-stall priority.

## Interface
- `XLEN`, 32, PC/data width.
- `BTB_ENTRIES`, 16, BTB depth; power of two, ≥2.
- `RESET_PC`, 0, PC value loaded on reset.
- `JR_WORD_ADDR`, 1, when 1 the `jr` target is `jr_reg_i << 2`; when 0 it is `jr_reg_i` unshifted.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall_i`  in  1  hold PC (hazard stall).
- `redirect_i`  in  1  mispredict/flush from EX; load the redirect target.
- `redirect_jr_i`  in  1  redirect is a `jr`; target comes from `jr_reg_i`.
- `jr_reg_i`  in  XLEN  reg[rs] for `jr`.
- `redirect_pc_i`  in  XLEN  corrected target for non-`jr` redirects (taken target or fall-through).
- `upd_valid_i`  in  1  resolved branch/jump update.
- `upd_pc_i`  in  XLEN  PC of the resolved instruction.
- `upd_taken_i`  in  1  resolved direction.
- `upd_target_i`  in  XLEN  resolved taken target.
- `pc_o`  out  XLEN  current fetch PC (registered).
- `pred_taken_o`  out  1  prediction for `pc_o` (combinational from state).
- `pred_target_o`  out  XLEN  predicted next PC for `pc_o`.

## Operation
- Index = `pc[IDX+1:2]`, with IDX = log2(BTB_ENTRIES). Tag = `pc[XLEN-1:IDX+2]`. Each entry holds valid, tag, target (XLEN) and a 2-bit counter (0 SNT, 1 WNT, 2 WT, 3 ST).
- Hit = valid && tag match. `pred_taken_o` = hit && ctr[1]. `pred_target_o` = pred_taken_o ? entry.target : `pc_o`+4.
- Next-PC priority: reset > `redirect_i` > `stall_i` > prediction.
  - On redirect: PC = `redirect_jr_i` ? jr target : `redirect_pc_i`. A redirect overrides a stall.
  - On stall without redirect: PC holds.
  - Otherwise: PC = `pred_target_o`.
- Update, applied to the entry indexed by `upd_pc_i`. Updates apply regardless of stall and redirect.
  - Hit, taken: ctr = sat_inc; target = `upd_target_i`.
  - Hit, not taken: ctr = sat_dec; target unchanged.
  - Miss, taken: allocate the entry (overwriting any prior occupant): valid=1, new tag, target, ctr=2.
  - Miss, not taken: no write.
- Arithmetic: PC+4 and the `jr` shift are truncated to XLEN (wrap modulo 2^XLEN). Bits [1:0] of all targets pass through unmodified.

## Timing
- Reset (asynchronous assert, synchronous-safe release): `pc_o`=RESET_PC, all valid=0, all ctr=0, hence `pred_taken_o`=0 and `pred_target_o`=RESET_PC+4.
- `pc_o` changes only on a rising `clk` edge. Redirect latency is 1 cycle: target appears on `pc_o` the cycle after `redirect_i` is sampled.
- A BTB update is visible to prediction the cycle after `upd_valid_i`. There is no same-cycle bypass: a prediction on the same index in the update cycle uses pre-update state.
- Reset asserted mid-operation clears the PC and BTB immediately; in-flight updates are discarded.
- Counters saturate: ST+taken stays 3; SNT+not-taken stays 0.

## Structure
- Shared package `pc_pkg`: counter encodings (CTR_SNT/WNT/WT/ST), `sat_inc`/`sat_dec` functions, default RESET_PC.
- One sub-module, `pc_btb`: BTB storage with a combinational read port (indexed by `pc_o`) and a synchronous write/update port, plus reset clearing. Counter update logic lives in `pc_btb`. PC register and next-PC mux stay in `pc_gen_bp`.

## Test plan
- Reset then free-run, no redirects: `pc_o` = 0,4,8,12…; `pred_taken_o`=0 throughout.
- Update pc=0x10, taken, target 0x40, then fetch reaches 0x10: next `pc_o`=0x40. Then update not-taken twice: ctr 2→1→0, and fetch from 0x10 goes to 0x14.
- `redirect_i`=1 with `redirect_jr_i`=1 and `jr_reg_i`=0x20 (JR_WORD_ADDR=1), while `stall_i`=1: next `pc_o`=0x80. With JR_WORD_ADDR=0: next `pc_o`=0x20.
- `stall_i`=1 for 3 cycles with no redirect: `pc_o` holds; BTB updates issued during the stall take effect.
- Aliasing (BTB_ENTRIES=16): entry for 0x10 allocated, then update 0x50 taken → 0x100. Now 0x10 misses (predicts 0x14) and 0x50 hits; `pc_o`=0xFFFFFFFC with no hit wraps to 0x0.
- Assert `reset_n` low mid-run, between clock edges: `pc_o`=RESET_PC immediately; previously trained 0x10 now predicts not-taken.
